multicycle_control_fsm: RTL and testbench

//  Main control FSM of the multicycle RV32I core. Sequences fetch/decode/execute/memory/writeback
//  and drives the datapath mux selects, write strobes and the 2-bit alu_op consumed by the ALU decoder
//  (00 = ADD, 01 = SUB, 10 = decode from opcode/funct3/funct7). Handshakes with unified memory via mem_ready.

---
 rtl/multicycle_control_fsm_if.sv | 32 +++
 rtl/multicycle_control_fsm.sv | 161 ++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the RV32I datapath/memory.
// master = control FSM side, slave = datapath side.
interface multicycle_control_fsm_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alu_zero;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       bus_error;
    logic       illegal_instr;

    modport master (
        input  opcode, funct3, alu_zero, mem_ready,
        output pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
        output alu_src_a, alu_src_b, alu_op, result_src, bus_error, illegal_instr
    );

    modport slave (
        output opcode, funct3, alu_zero, mem_ready,
        input  pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
        input  alu_src_a, alu_src_b, alu_op, result_src, bus_error, illegal_instr
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core (fetch/decode/execute/mem/writeback).
// Define ILLEGAL_TRAP_EN to trap illegal opcodes; otherwise they execute as NOPs.
module multicycle_control_fsm #(
    parameter int WAIT_MAX = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    multicycle_control_fsm_if.master    bus
);
    localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_LUI, S_ALUWB, S_BRANCH, S_JAL, S_JALR,
        S_LINK, S_BUS_ERR, S_TRAP
    } state_t;

    typedef struct packed {
        logic       adr_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       pc_write;
        logic       fetch;
        logic       branch;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
    } ctl_t;

    function automatic ctl_t decode_ctl(state_t s);
        ctl_t c;
        c = '0;
        unique case (s)
            S_FETCH: begin
                c.mem_read = 1'b1; c.fetch = 1'b1;
                c.src_b = 2'b10; c.result_src = 2'b10;
            end
            S_DECODE:   begin c.src_a = 2'b01; c.src_b = 2'b01; end
            S_MEMADR:   begin c.src_a = 2'b10; c.src_b = 2'b01; end
            S_MEMREAD:  begin c.adr_src = 1'b1; c.mem_read = 1'b1; end
            S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
            S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
            S_EXEC_R:   begin c.src_a = 2'b10; c.alu_op = 2'b10; end
            S_EXEC_I, S_LUI: begin
                c.src_a = 2'b10; c.src_b = 2'b01; c.alu_op = 2'b10;
            end
            S_ALUWB:    c.reg_write = 1'b1;
            S_BRANCH:   begin c.src_a = 2'b10; c.alu_op = 2'b10; c.branch = 1'b1; end
            S_JAL:      begin c.src_a = 2'b01; c.src_b = 2'b10; c.pc_write = 1'b1; end
            S_JALR: begin
                c.src_a = 2'b10; c.src_b = 2'b01;
                c.result_src = 2'b10; c.pc_write = 1'b1;
            end
            S_LINK: begin
                c.src_a = 2'b01; c.src_b = 2'b10;
                c.result_src = 2'b10; c.reg_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    localparam ctl_t FETCH_CTL = decode_ctl(S_FETCH);

    state_t        state_q, state_d;
    ctl_t          ctl_q, ctl_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_error_q, bus_error_d;
    logic          illegal_q, illegal_d;
    logic          wait_st;
    logic          timeout;
    logic          br_take;

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        bus_error_d = bus_error_q;
        illegal_d   = illegal_q;
        wait_st     = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                      (state_q == S_MEMWRITE);
        timeout     = wait_st && !bus.mem_ready && (WAIT_MAX != 0) &&
                      (int'(cnt_q) + 1 == WAIT_MAX);
        unique case (state_q)
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (bus.opcode)
                    7'b0000011, 7'b0100011: state_d = S_MEMADR;
                    7'b0110011: state_d = S_EXEC_R;
                    7'b0010011: state_d = S_EXEC_I;
                    7'b1100011: state_d = S_BRANCH;
                    7'b1101111: state_d = S_JAL;
                    7'b1100111: state_d = S_JALR;
                    7'b0110111: state_d = S_LUI;
                    7'b0010111: state_d = S_ALUWB;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
`else
                        state_d   = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR:   state_d = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC_R, S_EXEC_I, S_LUI, S_JAL: state_d = S_ALUWB;
            S_JALR:     state_d = S_LINK;
            S_MEMWB, S_ALUWB, S_BRANCH, S_LINK: state_d = S_FETCH;
            S_BUS_ERR, S_TRAP: state_d = state_q;
            default:    state_d = S_FETCH;
        endcase
        // mem_ready has priority: the timeout only fires on a still-pending access
        if (wait_st && !bus.mem_ready) begin
            if (timeout) begin
                state_d     = S_BUS_ERR;
                bus_error_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        ctl_d = decode_ctl(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FETCH;
            ctl_q       <= FETCH_CTL;
            cnt_q       <= '0;
            bus_error_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctl_q       <= ctl_d;
            cnt_q       <= cnt_d;
            bus_error_q <= bus_error_d;
            illegal_q   <= illegal_d;
        end
    end

    assign br_take = bus.alu_zero ^ bus.funct3[0] ^ bus.funct3[2];

    assign bus.pc_write  = !rst && (ctl_q.pc_write ||
                                    (ctl_q.fetch && bus.mem_ready) ||
                                    (ctl_q.branch && br_take));
    assign bus.ir_write  = !rst && ctl_q.fetch && bus.mem_ready;
    assign bus.mem_read  = !rst && ctl_q.mem_read;
    assign bus.mem_write = !rst && ctl_q.mem_write;
    assign bus.reg_write = !rst && ctl_q.reg_write;

    assign bus.adr_src       = ctl_q.adr_src;
    assign bus.alu_src_a     = ctl_q.src_a;
    assign bus.alu_src_b     = ctl_q.src_b;
    assign bus.alu_op        = ctl_q.alu_op;
    assign bus.result_src    = ctl_q.result_src;
    assign bus.bus_error     = bus_error_q;
    assign bus.illegal_instr = illegal_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: instruction table with cycle/strobe scoreboard,
// plus directed sequences for waits, branches, JALR, timeout, illegal opcode and reset.
module tb_multicycle_control_fsm;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_control_fsm_if bus ();
    multicycle_control_fsm #(.WAIT_MAX(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       zero;
        int         waits;
        int         cyc, pcw, regw, memw;
    } vec_t;

    typedef struct {
        int cyc, pcw, regw, memw;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   wait_left = 0;
    logic force_low = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int is_fetch();
        return int'(bus.mem_read && !bus.adr_src);
    endfunction

    // Advance one cycle; mem_ready is chosen from the current (Moore) state.
    task automatic step();
        @(negedge clk);
        #1;
        if (force_low) bus.mem_ready = 1'b0;
        else if (bus.adr_src && wait_left > 0) begin
            bus.mem_ready = 1'b0;
            wait_left--;
        end else bus.mem_ready = 1'b1;
        #1;
    endtask

    task automatic release_rst();
        rst = 1'b0;
        #1;
        bus.mem_ready = !force_low;
        #1;
    endtask

    task automatic add_vec(input logic [6:0] op, input logic [2:0] f3,
                           input logic z, input int w, input int cyc,
                           input int pcw, input int regw, input int memw);
        vec_t v;
        v.op = op; v.f3 = f3; v.zero = z; v.waits = w;
        v.cyc = cyc; v.pcw = pcw; v.regw = regw; v.memw = memw;
        vecs.push_back(v);
    endtask

    // Entered with the FETCH cycle of this instruction already sampled.
    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        int n, pcw, regw, memw, done;
        n = 1; pcw = int'(bus.pc_write);
        regw = int'(bus.reg_write); memw = int'(bus.mem_write);
        done = 0;
        bus.opcode = v.op; bus.funct3 = v.f3; bus.alu_zero = v.zero;
        wait_left = v.waits;
        e.cyc = v.cyc; e.pcw = v.pcw; e.regw = v.regw; e.memw = v.memw;
        sbq.push_back(e);
        for (int k = 0; k < 24; k++) begin
            step();
            if (is_fetch() != 0) begin
                done = 1;
                break;
            end
            n++;
            pcw  += int'(bus.pc_write);
            regw += int'(bus.reg_write);
            memw += int'(bus.mem_write);
        end
        e = sbq.pop_front();
        chk($sformatf("v%0d_done", idx), done, 1);
        chk($sformatf("v%0d_cycles", idx), n, e.cyc);
        chk($sformatf("v%0d_pc_write", idx), pcw, e.pcw);
        chk($sformatf("v%0d_reg_write", idx), regw, e.regw);
        chk($sformatf("v%0d_mem_write", idx), memw, e.memw);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        add_vec(7'b0110011, 3'b000, 1'b0, 0, 4, 1, 1, 0);
        add_vec(7'b0010011, 3'b000, 1'b0, 0, 4, 1, 1, 0);
        add_vec(7'b0110111, 3'b000, 1'b0, 0, 4, 1, 1, 0);
        add_vec(7'b0010111, 3'b000, 1'b0, 0, 3, 1, 1, 0);
        add_vec(7'b0000011, 3'b010, 1'b0, 3, 8, 1, 1, 0);
        add_vec(7'b0000011, 3'b010, 1'b0, 0, 5, 1, 1, 0);
        add_vec(7'b0100011, 3'b010, 1'b0, 2, 6, 1, 0, 3);
        add_vec(7'b1100011, 3'b000, 1'b1, 0, 3, 2, 0, 0);
        add_vec(7'b1100011, 3'b000, 1'b0, 0, 3, 1, 0, 0);
        add_vec(7'b1100011, 3'b001, 1'b0, 0, 3, 2, 0, 0);
        add_vec(7'b1100011, 3'b001, 1'b1, 0, 3, 1, 0, 0);
        add_vec(7'b1100011, 3'b101, 1'b1, 0, 3, 2, 0, 0);
        add_vec(7'b1100011, 3'b100, 1'b0, 0, 3, 2, 0, 0);
        add_vec(7'b1101111, 3'b000, 1'b0, 0, 4, 2, 1, 0);
        add_vec(7'b1100111, 3'b000, 1'b0, 0, 4, 2, 1, 0);
`ifndef ILLEGAL_TRAP_EN
        add_vec(7'h7F, 3'b000, 1'b0, 0, 2, 1, 0, 0);
`endif

        rst = 1'b1;
        bus.opcode = 7'h00; bus.funct3 = 3'b000;
        bus.alu_zero = 1'b0; bus.mem_ready = 1'b1;
        #1;
        chk("rst_mem_read", int'(bus.mem_read), 0);
        chk("rst_pc_write", int'(bus.pc_write), 0);
        chk("rst_ir_write", int'(bus.ir_write), 0);
        chk("rst_bus_error", int'(bus.bus_error), 0);
        chk("rst_illegal", int'(bus.illegal_instr), 0);
        @(negedge clk);
        @(negedge clk);
        release_rst();
        chk("post_rst_fetch", is_fetch(), 1);
        chk("post_rst_src_b", int'(bus.alu_src_b), 2);
        chk("post_rst_result_src", int'(bus.result_src), 2);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // R-type walk-through
        chk("r_fetch_ir_write", int'(bus.ir_write), 1);
        bus.opcode = 7'b0110011; bus.funct3 = 3'b000;
        step();
        chk("r_dec_a", int'(bus.alu_src_a), 1);
        chk("r_dec_b", int'(bus.alu_src_b), 1);
        step();
        chk("r_exec_alu_op", int'(bus.alu_op), 2);
        chk("r_exec_a", int'(bus.alu_src_a), 2);
        chk("r_exec_b", int'(bus.alu_src_b), 0);
        chk("r_exec_reg_write", int'(bus.reg_write), 0);
        step();
        chk("r_wb_reg_write", int'(bus.reg_write), 1);
        chk("r_wb_result_src", int'(bus.result_src), 0);
        step();
        chk("r_back_fetch", is_fetch(), 1);
        chk("r_fetch_reg_write", int'(bus.reg_write), 0);

        // Load with three wait cycles in MEMREAD
        bus.opcode = 7'b0000011; wait_left = 3;
        step();
        step();
        chk("ld_memadr_a", int'(bus.alu_src_a), 2);
        chk("ld_memadr_b", int'(bus.alu_src_b), 1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("ld_mr%0d_mem_read", k), int'(bus.mem_read), 1);
            chk($sformatf("ld_mr%0d_adr_src", k), int'(bus.adr_src), 1);
        end
        step();
        chk("ld_wb_reg_write", int'(bus.reg_write), 1);
        chk("ld_wb_result_src", int'(bus.result_src), 1);
        chk("ld_wb_bus_error", int'(bus.bus_error), 0);
        step();
        chk("ld_back_fetch", is_fetch(), 1);

        // BNE: pc_write follows alu_zero within the BRANCH cycle
        bus.opcode = 7'b1100011; bus.funct3 = 3'b001; bus.alu_zero = 1'b0;
        step();
        step();
        chk("bne_nz_pc_write", int'(bus.pc_write), 1);
        bus.alu_zero = 1'b1;
        #1;
        chk("bne_z_pc_write", int'(bus.pc_write), 0);
        step();
        chk("bne_back_fetch", is_fetch(), 1);

        // JALR then LINK
        bus.opcode = 7'b1100111; bus.funct3 = 3'b000;
        step();
        step();
        chk("jalr_pc_write", int'(bus.pc_write), 1);
        chk("jalr_result_src", int'(bus.result_src), 2);
        step();
        chk("link_reg_write", int'(bus.reg_write), 1);
        chk("link_a", int'(bus.alu_src_a), 1);
        chk("link_b", int'(bus.alu_src_b), 2);
        chk("link_result_src", int'(bus.result_src), 2);
        chk("link_pc_write", int'(bus.pc_write), 0);
        step();
        chk("link_back_fetch", is_fetch(), 1);

        // Illegal opcode
        bus.opcode = 7'h7F;
        step();
        chk("ill_dec_pc_write", int'(bus.pc_write), 0);
        step();
`ifdef ILLEGAL_TRAP_EN
        chk("ill_trap_flag", int'(bus.illegal_instr), 1);
        chk("ill_trap_mem_read", int'(bus.mem_read), 0);
        step();
        chk("ill_trap_stuck", int'(bus.illegal_instr), 1);
        chk("ill_trap_pc_write", int'(bus.pc_write), 0);
        chk("ill_trap_reg_write", int'(bus.reg_write), 0);
        rst = 1'b1;
        #1;
        chk("ill_rst_clear", int'(bus.illegal_instr), 0);
        @(negedge clk);
        release_rst();
`else
        chk("ill_nop_fetch", is_fetch(), 1);
        chk("ill_nop_flag", int'(bus.illegal_instr), 0);
`endif
        chk("ill_after_fetch", is_fetch(), 1);

        // Reset asserted while a store is waiting
        bus.opcode = 7'b0100011; wait_left = 2;
        step();
        step();
        step();
        chk("st_mem_write", int'(bus.mem_write), 1);
        rst = 1'b1;
        #1;
        chk("st_rst_mem_write", int'(bus.mem_write), 0);
        chk("st_rst_mem_read", int'(bus.mem_read), 0);
        wait_left = 0;
        @(negedge clk);
        release_rst();
        chk("st_rst_fetch", is_fetch(), 1);
        chk("st_rst_adr_src", int'(bus.adr_src), 0);

        // FETCH timeout with mem_ready stuck low (WAIT_MAX = 4)
        rst = 1'b1;
        force_low = 1'b1;
        @(negedge clk);
        release_rst();
        step();
        step();
        step();
        chk("to_wait4_bus_error", int'(bus.bus_error), 0);
        chk("to_wait4_mem_read", int'(bus.mem_read), 1);
        step();
        chk("to_bus_error", int'(bus.bus_error), 1);
        chk("to_mem_read", int'(bus.mem_read), 0);
        chk("to_pc_write", int'(bus.pc_write), 0);
        force_low = 1'b0;
        step();
        chk("to_sticky", int'(bus.bus_error), 1);
        chk("to_ir_write", int'(bus.ir_write), 0);
        rst = 1'b1;
        #1;
        chk("to_rst_clear", int'(bus.bus_error), 0);
        @(negedge clk);
        release_rst();
        chk("to_rst_fetch", is_fetch(), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
